// File: rtl/es_pkg.sv
// Shared encodings for the CPU I/O port responder: port selects, STATUS/CTRL
// bit positions and the input-capture FSM states.
package es_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  // cpu_sel encodings
  typedef enum logic [1:0] {
    SEL_DATA    = 2'd0,
    SEL_STATUS  = 2'd1,
    SEL_CTRL    = 2'd2,
    SEL_SCRATCH = 2'd3
  } sel_e;

  // STATUS byte layout: {count[2:0], 2'b00, ovf, in_full, out_full}
  localparam int unsigned ST_OUT_FULL = 0;
  localparam int unsigned ST_IN_FULL  = 1;
  localparam int unsigned ST_OVF      = 2;
  localparam int unsigned ST_CNT_LSB  = 5;

  // CTRL byte layout
  localparam int unsigned CTRL_OVF_CLR   = 0;
  localparam int unsigned CTRL_IRQ_IN    = 1;
  localparam int unsigned CTRL_IRQ_EMPTY = 2;

  // Input holding register state
  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_HELD  = 1'b1
  } in_state_e;

  // Assemble the STATUS byte from its fields
  function automatic logic [DATA_W-1:0] status_byte(input logic [CNT_W-1:0] cnt,
                                                    input logic             ovf,
                                                    input logic             in_full,
                                                    input logic             out_full);
    logic [DATA_W-1:0] s;
    s                = '0;
    s[ST_CNT_LSB +: CNT_W] = cnt;
    s[ST_OVF]        = ovf;
    s[ST_IN_FULL]    = in_full;
    s[ST_OUT_FULL]   = out_full;
    return s;
  endfunction

endpackage

// File: rtl/es_fifo.sv
// Show-ahead output FIFO; DEPTH must be a power of two (2 or 4).
// Pushes into a full FIFO are dropped, even with a simultaneous pop.
module es_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic [2:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == 3'(DEPTH));
  assign empty_o = (count_q == 3'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head never shows stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/es_port_ctrl.sv
// CPU I/O port responder: DATA writes feed an output FIFO drained to the device,
// device bytes are captured into a one-entry holding register read on DATA.
// Optional feature macro: ES_IRQ_EN (adds irq output and CTRL mask bits 2:1).
module es_port_ctrl
  import es_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   cpu_sel,
  input  logic         cpu_we,
  input  logic [W-1:0] cpu_wdata,
  input  logic         cpu_re,
  output logic [W-1:0] cpu_rdata,
  output logic [W-1:0] dev_out_data,
  output logic         dev_out_valid,
  input  logic         dev_out_ready,
  input  logic [W-1:0] dev_in_data,
  input  logic         dev_in_valid,
  output logic         dev_in_ready
`ifdef ES_IRQ_EN
  ,
  output logic         irq
`endif
);

  sel_e        sel;
  logic        wr_data, wr_ctrl, wr_scratch, rd_data;
  logic [2:0]  fifo_count;
  logic        fifo_full, fifo_empty;

  in_state_e   state_q, state_d;
  logic [W-1:0] in_reg_q, in_reg_d;
  logic        ovf_q, ovf_d;
  logic [W-1:0] scratch_q, scratch_d;
  logic [W-1:0] rdata_q, rd_mux;
  logic        in_full;
  logic [1:0]  mask;

  assign sel        = sel_e'(cpu_sel);
  assign wr_data    = cpu_we && (sel == SEL_DATA);
  assign wr_ctrl    = cpu_we && (sel == SEL_CTRL);
  assign wr_scratch = cpu_we && (sel == SEL_SCRATCH);
  assign rd_data    = cpu_re && (sel == SEL_DATA);
  assign in_full    = (state_q == IN_HELD);

  es_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (wr_data),
    .wdata_i (cpu_wdata),
    .pop_i   (dev_out_ready),
    .rdata_o (dev_out_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dev_out_valid = !fifo_empty;
  assign dev_in_ready  = (state_q == IN_EMPTY);
  assign cpu_rdata     = rdata_q;

  // Input capture FSM next state and holding register load
  always_comb begin
    state_d  = state_q;
    in_reg_d = in_reg_q;
    unique case (state_q)
      IN_EMPTY: if (dev_in_valid) begin
        state_d  = IN_HELD;
        in_reg_d = dev_in_data;
      end
      IN_HELD: if (rd_data) state_d = IN_EMPTY;
      default: state_d = IN_EMPTY;
    endcase
  end

  // Sticky overflow (clear wins) and scratch register next state
  always_comb begin
    ovf_d     = ovf_q;
    scratch_d = scratch_q;
    if (wr_data && fifo_full)              ovf_d = 1'b1;
    if (wr_ctrl && cpu_wdata[CTRL_OVF_CLR]) ovf_d = 1'b0;
    if (wr_scratch)                        scratch_d = cpu_wdata;
  end

  // Read mux over pre-write register state
  always_comb begin
    rd_mux = '0;
    unique case (sel)
      SEL_DATA:    rd_mux = in_reg_q;
      SEL_STATUS:  rd_mux = W'(status_byte(fifo_count, ovf_q, in_full, fifo_full));
      SEL_CTRL:    rd_mux = W'({mask, 1'b0});
      SEL_SCRATCH: rd_mux = scratch_q;
      default:     rd_mux = '0;
    endcase
  end

  // Core state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IN_EMPTY;
      in_reg_q  <= '0;
      ovf_q     <= 1'b0;
      scratch_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      in_reg_q  <= in_reg_d;
      ovf_q     <= ovf_d;
      scratch_q <= scratch_d;
      if (cpu_re) rdata_q <= rd_mux;
    end
  end

`ifdef ES_IRQ_EN
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  assign mask = mask_q;
  assign irq  = irq_q;

  // Interrupt mask load and interrupt condition
  always_comb begin
    mask_d = mask_q;
    if (wr_ctrl) mask_d = cpu_wdata[CTRL_IRQ_EMPTY:CTRL_IRQ_IN];
    irq_d  = (mask_q[0] && in_full) || (mask_q[1] && fifo_empty) || ovf_q;
  end

  // Interrupt registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign mask = 2'b00;
`endif

endmodule

// File: tb/tb_es_port_ctrl.sv
// Scoreboard bench for es_port_ctrl: expected read data and device bytes are
// queued at stimulus time and checked by independent monitors.
module tb_es_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cpu_sel;
  logic       cpu_we, cpu_re;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic [7:0] dev_out_data, dev_in_data;
  logic       dev_out_valid, dev_out_ready;
  logic       dev_in_valid, dev_in_ready;
`ifdef ES_IRQ_EN
  logic       irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] rd_q[$];
  logic [7:0] out_q[$];
  logic       rd_pend = 1'b0;

  localparam logic [1:0] S_DATA = 2'd0, S_STATUS = 2'd1, S_CTRL = 2'd2, S_SCRATCH = 2'd3;

  always #5 clk = ~clk;

  es_port_ctrl #(.DEPTH(4), .W(8)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .cpu_sel       (cpu_sel),
    .cpu_we        (cpu_we),
    .cpu_wdata     (cpu_wdata),
    .cpu_re        (cpu_re),
    .cpu_rdata     (cpu_rdata),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready)
`ifdef ES_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Output stream monitor: every accepted byte must match the queue head
  always @(posedge clk) begin
    if (rst_n && dev_out_valid && dev_out_ready) begin
      if (out_q.size() == 0) chk("out_unexpected", dev_out_data, 8'hxx);
      else chk("out_byte", dev_out_data, out_q.pop_front());
    end
    if (rst_n && cpu_re) rd_pend <= 1'b1;
  end

  // Read monitor: cpu_rdata is compared one cycle after the strobe
  always @(negedge clk) begin
    if (rd_pend) begin
      rd_pend <= 1'b0;
      if (rd_q.size() == 0) chk("rd_unexpected", cpu_rdata, 8'hxx);
      else chk("rd_data", cpu_rdata, rd_q.pop_front());
    end
  end

  task automatic cpu_write(input logic [1:0] s, input logic [7:0] d);
    cpu_we = 1'b1; cpu_sel = s; cpu_wdata = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] s, input logic [7:0] exp);
    cpu_re = 1'b1; cpu_sel = s; rd_q.push_back(exp);
    @(negedge clk);
    cpu_re = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit accepted);
    if (accepted) out_q.push_back(d);
    cpu_write(S_DATA, d);
  endtask

  task automatic drain();
    dev_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!dev_out_valid) break;
      @(negedge clk);
    end
    chk("drain_done", {7'b0, dev_out_valid}, 8'h00);
    dev_out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_sel = S_DATA; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = '0;
    dev_out_ready = 1'b0; dev_in_data = '0; dev_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_out_valid", {7'b0, dev_out_valid}, 8'h00);
    chk("rst_in_ready", {7'b0, dev_in_ready}, 8'h01);
`ifdef ES_IRQ_EN
    chk("rst_irq", {7'b0, irq}, 8'h00);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(S_STATUS, 8'h00);

    // Three queued bytes, then a consecutive drain
    push(8'h11, 1);
    chk("valid_after_push", {7'b0, dev_out_valid}, 8'h01);
    chk("head_data", dev_out_data, 8'h11);
    push(8'h22, 1);
    push(8'h33, 1);
    cpu_read(S_STATUS, 8'h60);
    dev_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("valid_after_drain", {7'b0, dev_out_valid}, 8'h00);
    dev_out_ready = 1'b0;

    // Overflow: fifth byte dropped, ovf sticky until CTRL clear
    push(8'hA0, 1); push(8'hA1, 1); push(8'hA2, 1); push(8'hA3, 1);
    push(8'hA4, 0);
    cpu_read(S_STATUS, 8'h85);
    cpu_write(S_CTRL, 8'h01);
    cpu_read(S_STATUS, 8'h81);
    drain();
    cpu_read(S_STATUS, 8'h00);

    // Input capture and back-pressure on a second offer
    dev_in_valid = 1'b1; dev_in_data = 8'h5C;
    @(negedge clk);
    chk("in_ready_low", {7'b0, dev_in_ready}, 8'h00);
    dev_in_data = 8'h77;
    @(negedge clk);
    chk("in_ready_held", {7'b0, dev_in_ready}, 8'h00);
    cpu_read(S_STATUS, 8'h02);
    cpu_read(S_DATA, 8'h5C);
    chk("in_ready_free", {7'b0, dev_in_ready}, 8'h01);
    @(negedge clk);
    chk("in_ready_77", {7'b0, dev_in_ready}, 8'h00);
    dev_in_valid = 1'b0;
    cpu_read(S_DATA, 8'h77);
    cpu_read(S_DATA, 8'h77);
    chk("stale_read_no_effect", {7'b0, dev_in_ready}, 8'h01);

    // Simultaneous push and pop at count=2
    push(8'h01, 1); push(8'h02, 1);
    dev_out_ready = 1'b1;
    push(8'h99, 1);
    dev_out_ready = 1'b0;
    cpu_read(S_STATUS, 8'h40);
    drain();

    // Write and read together: read returns pre-write scratch
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_sel = S_SCRATCH; cpu_wdata = 8'h5A;
    rd_q.push_back(8'h00);
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b0;
    cpu_read(S_SCRATCH, 8'h5A);
    cpu_write(S_STATUS, 8'hFF);
    cpu_read(S_STATUS, 8'h00);
    cpu_write(S_CTRL, 8'h06);
`ifdef ES_IRQ_EN
    cpu_read(S_CTRL, 8'h06);
`else
    cpu_read(S_CTRL, 8'h00);
`endif
    cpu_write(S_CTRL, 8'h00);

    // Push into a full FIFO during a pop is still dropped
    push(8'hB0, 1); push(8'hB1, 1); push(8'hB2, 1); push(8'hB3, 1);
    dev_out_ready = 1'b1;
    push(8'hB4, 0);
    dev_out_ready = 1'b0;
    cpu_read(S_STATUS, 8'h64);
    cpu_write(S_CTRL, 8'h01);
    cpu_read(S_STATUS, 8'h60);
    drain();

`ifdef ES_IRQ_EN
    // Interrupt on held input byte
    cpu_write(S_CTRL, 8'h02);
    dev_in_valid = 1'b1; dev_in_data = 8'h01;
    @(negedge clk);
    dev_in_valid = 1'b0;
    chk("irq_lag", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("irq_set", {7'b0, irq}, 8'h01);
    cpu_read(S_DATA, 8'h01);
    chk("irq_still", {7'b0, irq}, 8'h01);
    @(negedge clk);
    chk("irq_clear", {7'b0, irq}, 8'h00);
    cpu_write(S_CTRL, 8'h00);
`endif

    // Reset mid-drain discards queued bytes and the held input byte
    dev_in_valid = 1'b1; dev_in_data = 8'hE7;
    @(negedge clk);
    dev_in_valid = 1'b0;
    cpu_write(S_SCRATCH, 8'hC3);
    cpu_read(S_SCRATCH, 8'hC3);
    push(8'hD0, 1); push(8'hD1, 0); push(8'hD2, 0);
    dev_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {7'b0, dev_out_valid}, 8'h00);
    chk("mid_rst_in_ready", {7'b0, dev_in_ready}, 8'h01);
    chk("mid_rst_rdata", cpu_rdata, 8'h00);
    dev_out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(S_SCRATCH, 8'h00);
    cpu_read(S_STATUS, 8'h00);
    cpu_read(S_DATA, 8'h00);

    repeat (3) @(negedge clk);
    chk("out_q_empty", 8'(out_q.size()), 8'h00);
    chk("rd_q_empty", 8'(rd_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
